// File: rtl/adc_capture_serializer_pkg.sv
// ============================================================================
// Module : rfsoc_config (package)
// Brief  : Shared configuration constants and capture FSM state type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rfsoc_config;

  localparam int config_reg_width = 32;
  localparam int ADC_CAP_DEPTH    = 64;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_CAPTURE = 2'd1,
    CAP_DONE    = 2'd2,
    CAP_READOUT = 2'd3
  } adc_cap_state_t;

endpackage

`default_nettype wire

// File: rtl/adc_capture_serializer_ram.sv
// ============================================================================
// Module : adc_capture_ram
// Brief  : Simple dual-port capture RAM, synchronous write, registered read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adc_capture_ram #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Read data holds between reads so it can serve as a one-word prefetch slot.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= r_mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/adc_capture_serializer.sv
// ============================================================================
// Module : adc_capture_serializer
// Brief  : Per-channel ADC capture (shifted) into RAM, then 32-bit AXIS readout.
//          Optional ADC_CAPTURE_STATS_EN adds trig_miss_cnt output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adc_capture_serializer
  import rfsoc_config::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int NSAMP    = 8,
  parameter int OUT_W    = 32,
  parameter int DEPTH    = ADC_CAP_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trigger,
  input  logic [config_reg_width-1:0] run_cycles,
  input  logic [config_reg_width-1:0] shift_val,
  input  logic                        readout_en,
  input  logic [SAMPLE_W*NSAMP-1:0]   s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [OUT_W-1:0]            m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        busy,
  output logic                        overflow
`ifdef ADC_CAPTURE_STATS_EN
  ,
  output logic [15:0]                 trig_miss_cnt
`endif
);

  localparam int c_word_w = SAMPLE_W * NSAMP;
  localparam int c_bpw    = c_word_w / OUT_W;
  localparam int c_aw     = $clog2(DEPTH);
  localparam int c_cw     = c_aw + 1;
  localparam int c_sw     = $clog2(SAMPLE_W);
  localparam int c_slw    = (c_bpw > 1) ? $clog2(c_bpw) : 1;
  localparam int c_bw     = $clog2(DEPTH * c_bpw) + 1;

  adc_cap_state_t r_state, w_state_next;

  logic                r_trig_d;
  logic [c_cw-1:0]     r_n;
  logic [c_sw-1:0]     r_sh;
  logic [c_cw-1:0]     r_wr_cnt;
  logic [c_cw-1:0]     r_rd_cnt;
  logic                r_pf_full;
  logic [c_word_w-1:0] r_word;
  logic                r_word_valid;
  logic [c_slw-1:0]    r_slice;
  logic [OUT_W-1:0]    r_tdata;
  logic                r_tvalid;
  logic [c_bw-1:0]     r_beat_cnt;
  logic                r_overflow;

  logic                w_trig_rise;
  logic [c_cw-1:0]     w_n_clamped;
  logic [c_sw-1:0]     w_sh_clamped;
  logic [c_word_w-1:0] w_shifted;
  logic [c_word_w-1:0] w_rd_data;
  logic [OUT_W-1:0]    w_slice [c_bpw];
  logic [c_bw-1:0]     w_total;
  logic                w_wr_en, w_wr_last;
  logic                w_in_ro, w_out_hs, w_out_ready, w_take;
  logic                w_word_done, w_load_word, w_rd_en, w_last_beat;

  assign w_trig_rise  = trigger & ~r_trig_d;
  assign w_n_clamped  = (run_cycles > config_reg_width'(DEPTH)) ? c_cw'(DEPTH)
                                                                : run_cycles[c_cw-1:0];
  assign w_sh_clamped = (shift_val > config_reg_width'(SAMPLE_W-1)) ? c_sw'(SAMPLE_W-1)
                                                                    : shift_val[c_sw-1:0];

  for (genvar k = 0; k < NSAMP; k++) begin : g_shift
    assign w_shifted[k*SAMPLE_W +: SAMPLE_W] =
      $signed(s_axis_tdata[k*SAMPLE_W +: SAMPLE_W]) >>> r_sh;
  end

  for (genvar b = 0; b < c_bpw; b++) begin : g_slice
    assign w_slice[b] = r_word[b*OUT_W +: OUT_W];
  end

  assign w_wr_en   = (r_state == CAP_CAPTURE) && s_axis_tvalid;
  assign w_wr_last = w_wr_en && (r_wr_cnt == r_n - c_cw'(1));

  // Readout pipeline: RAM read-data register acts as a one-word prefetch,
  // r_word is the word being sliced, r_tdata/r_tvalid is the AXIS output stage.
  assign w_in_ro     = (r_state == CAP_READOUT);
  assign w_out_hs    = r_tvalid && m_axis_tready;
  assign w_out_ready = !r_tvalid || m_axis_tready;
  assign w_take      = w_in_ro && r_word_valid && w_out_ready;
  assign w_word_done = w_take && (r_slice == c_slw'(c_bpw - 1));
  assign w_load_word = r_pf_full && (!r_word_valid || w_word_done);
  assign w_rd_en     = w_in_ro && (r_rd_cnt < r_n) && (!r_pf_full || w_load_word);
  assign w_total     = c_bw'(r_n) * c_bw'(c_bpw);
  assign w_last_beat = w_out_hs && (r_beat_cnt == w_total - c_bw'(1));

  adc_capture_ram #(
    .WIDTH (c_word_w),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_cnt[c_aw-1:0]),
    .wr_data (w_shifted),
    .rd_en   (w_rd_en),
    .rd_addr (r_rd_cnt[c_aw-1:0]),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= CAP_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    s_axis_tready = 1'b0;
    busy          = 1'b1;
    case (r_state)
      CAP_IDLE: begin
        busy = 1'b0;
        if (w_trig_rise)
          w_state_next = (w_n_clamped == '0) ? CAP_DONE : CAP_CAPTURE;
      end
      CAP_CAPTURE: begin
        s_axis_tready = 1'b1;
        if (w_wr_last) w_state_next = CAP_DONE;
      end
      CAP_DONE: begin
        if (readout_en) w_state_next = (r_n == '0) ? CAP_IDLE : CAP_READOUT;
      end
      CAP_READOUT: begin
        if (w_last_beat) w_state_next = CAP_IDLE;
      end
      default: w_state_next = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_trig_d     <= 1'b0;
      r_n          <= '0;
      r_sh         <= '0;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_pf_full    <= 1'b0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_slice      <= '0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_beat_cnt   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_trig_d <= trigger;
      if (r_state == CAP_IDLE && w_trig_rise) begin
        r_n          <= w_n_clamped;
        r_sh         <= w_sh_clamped;
        r_overflow   <= (run_cycles > config_reg_width'(DEPTH));
        r_wr_cnt     <= '0;
        r_rd_cnt     <= '0;
        r_beat_cnt   <= '0;
        r_pf_full    <= 1'b0;
        r_word_valid <= 1'b0;
        r_slice      <= '0;
      end
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + c_cw'(1);
      if (w_rd_en) r_rd_cnt <= r_rd_cnt + c_cw'(1);

      if (w_rd_en)          r_pf_full <= 1'b1;
      else if (w_load_word) r_pf_full <= 1'b0;

      if (w_load_word) begin
        r_word       <= w_rd_data;
        r_word_valid <= 1'b1;
      end else if (w_word_done) begin
        r_word_valid <= 1'b0;
      end

      if (w_take) begin
        r_tdata  <= w_slice[r_slice];
        r_tvalid <= 1'b1;
        r_slice  <= w_word_done ? '0 : r_slice + c_slw'(1);
      end else if (w_out_hs) begin
        r_tvalid <= 1'b0;
      end

      if (w_out_hs) r_beat_cnt <= r_beat_cnt + c_bw'(1);
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign overflow      = r_overflow;

`ifdef ADC_CAPTURE_STATS_EN
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      r_miss_cnt <= '0;
    else if (w_trig_rise && r_state != CAP_IDLE && r_miss_cnt != 16'hFFFF)
      r_miss_cnt <= r_miss_cnt + 16'd1;
  end

  assign trig_miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire
